// File: rtl/fft16_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fft16_stream_ctrl
//  Brief    : Frames a ready/valid sample stream into 16-sample frames for a
//             first-stage 16-point FFT pipeline, generates the pipeline clock
//             enable, zero-pads short frames and tags the 8 output beats.
//  Revision : 1.0  initial release
// ============================================================================
module fft16_stream_ctrl #(
    parameter int WIDTH        = 8,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    input  logic [WIDTH-1:0] s_re,
    input  logic [WIDTH-1:0] s_im,
    input  logic             flush,
    output logic             st_ce,
    output logic             st_valid_a,
    output logic [WIDTH-1:0] st_ar,
    output logic [WIDTH-1:0] st_ai,
    input  logic             st_valid_o,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_first,
    output logic             m_last,
    output logic             busy,
    output logic [2:0]       inflight,
    output logic             err_framing,
    input  logic             err_clr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_PAD  = 2'd2;

    localparam logic [2:0] c_max_inflight = 3'(MAX_INFLIGHT);
    localparam logic [3:0] c_last_idx     = 4'd15;

    logic [1:0]       state_q, state_d;
    logic [3:0]       in_cnt_q, in_cnt_d;
    logic [2:0]       out_cnt_q;
    logic [2:0]       inflight_q;
    logic             err_q;
    logic             valid_a_q;
    logic [WIDTH-1:0] ar_q, ai_q;

    logic w_ce;
    logic w_ready;
    logic w_accept;
    logic w_pad_beat;
    logic w_frame_start;
    logic w_m_last_hs;
    logic w_frm_err;

    // Output back-pressure freezes the entire pipeline, controller included.
    assign w_ce          = ~(st_valid_o & ~m_ready);
    assign w_accept      = s_valid & w_ready;
    assign w_frame_start = w_accept & (in_cnt_q == 4'd0);
    assign w_m_last_hs   = st_valid_o & m_ready & (out_cnt_q == 3'd7);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            in_cnt_q <= 4'd0;
        end else if (w_ce) begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        w_frm_err = 1'b0;
        case (state_q)
            S_IDLE, S_FILL: begin
                if (w_accept) begin
                    in_cnt_d = in_cnt_q + 4'd1;
                    if (in_cnt_q == c_last_idx) begin
                        // Missing s_last still closes the frame on sample 15.
                        w_frm_err = ~s_last;
                        state_d   = S_IDLE;
                    end else if (s_last) begin
                        w_frm_err = 1'b1;
                        state_d   = S_PAD;
                    end else if (flush) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else if ((state_q == S_FILL) && flush && (in_cnt_q != 4'd0)) begin
                    state_d = S_PAD;
                end
            end
            S_PAD: begin
                in_cnt_d = in_cnt_q + 4'd1;
                if (in_cnt_q == c_last_idx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                in_cnt_d = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ready    = w_ce & (state_q != S_PAD) &
                     ~((in_cnt_q == 4'd0) & (inflight_q == c_max_inflight));
        w_pad_beat = w_ce & (state_q == S_PAD);
    end

    // ------------------------------------------------------------------
    // Stage A-input register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_a_q <= 1'b0;
            ar_q      <= '0;
            ai_q      <= '0;
        end else if (w_ce) begin
            valid_a_q <= w_accept | w_pad_beat;
            if (w_accept) begin
                ar_q <= s_re;
                ai_q <= s_im;
            end else if (w_pad_beat) begin
                ar_q <= '0;
                ai_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output beat counter and frames-in-flight counter
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_cnt_q  <= 3'd0;
            inflight_q <= 3'd0;
        end else if (w_ce) begin
            if (st_valid_o & m_ready) begin
                out_cnt_q <= out_cnt_q + 3'd1;
            end
            case ({w_frame_start, w_m_last_hs})
                2'b10:   inflight_q <= inflight_q + 3'd1;
                2'b01:   inflight_q <= inflight_q - 3'd1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Sticky error runs outside the clock enable so err_clr works during a stall.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (w_frm_err) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign s_ready     = w_ready;
    assign st_ce       = w_ce;
    assign st_valid_a  = valid_a_q;
    assign st_ar       = ar_q;
    assign st_ai       = ai_q;
    assign m_valid     = st_valid_o;
    assign m_first     = st_valid_o & (out_cnt_q == 3'd0);
    assign m_last      = st_valid_o & (out_cnt_q == 3'd7);
    assign busy        = (state_q != S_IDLE) | (inflight_q != 3'd0);
    assign inflight    = inflight_q;
    assign err_framing = err_q;

endmodule
`default_nettype wire
